// File: rtl/dsp_lane_accumulator_if.sv
// Handshake and data bundle between the MAC P-word source, the lane accumulator
// and the drain logic that consumes group results.
interface dsp_lane_accumulator_if #(
  parameter int BEAT_W = 16
);
  logic [3:0]        prec;
  logic              active_chain;
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_data;
  logic [BEAT_W-1:0] out_beats;
  logic [3:0]        out_ovf;

  modport slave (
    input  prec, active_chain, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_beats, out_ovf
  );

  modport master (
    output prec, active_chain, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_beats, out_ovf
  );
endinterface

// File: rtl/dsp_lane_accumulator.sv
// Saturating per-lane (8/8/16/32 or chained 64) group accumulator for the MAC
// P word, with a 2-entry registered result FIFO toward the drain logic.
module dsp_lane_accumulator #(
  parameter int BEAT_W    = 16,
  parameter int OUT_DEPTH = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  dsp_lane_accumulator_if.slave bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACC = 1'b1} state_t;

  localparam logic [1:0] FULL = 2'(OUT_DEPTH);

  state_t            state_r, state_next_s;
  logic [3:0]        cfg_prec_r;
  logic              cfg_chain_r;
  logic [63:0]       acc_r;
  logic [BEAT_W-1:0] cnt_r;
  logic [3:0]        ovf_r;
  logic [1:0]        fill_r;
  logic [63:0]       head_data_r, tail_data_r;
  logic [BEAT_W-1:0] head_beats_r, tail_beats_r;
  logic [3:0]        head_ovf_r, tail_ovf_r;

  logic              in_ready_s, accept_s, push_s, pop_s;
  logic [3:0]        mask_s;
  logic              chain_s;
  logic [8:0]        s0_s, s1_s;
  logic [16:0]       s2_s;
  logic [32:0]       s3_s;
  logic [64:0]       sc_s;
  logic [63:0]       sum_s;
  logic [3:0]        sum_ovf_s, grp_ovf_s;
  logic [BEAT_W-1:0] cnt_inc_s;

  // A full buffer still accepts when the head is being drained this cycle.
  assign in_ready_s = (fill_r < FULL) || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign push_s     = accept_s && bus.in_last;
  assign pop_s      = (fill_r != 2'd0) && bus.out_ready;
  assign cnt_inc_s  = (cnt_r == {BEAT_W{1'b1}}) ? cnt_r : cnt_r + {{(BEAT_W-1){1'b0}}, 1'b1};
  assign grp_ovf_s  = ovf_r | sum_ovf_s;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (fill_r != 2'd0);
  assign bus.out_data  = head_data_r;
  assign bus.out_beats = head_beats_r;
  assign bus.out_ovf   = head_ovf_r;

  // Group state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state: a group is open between its first non-last beat and its last beat.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !bus.in_last) state_next_s = ACC;
        else                          state_next_s = IDLE;
      end
      ACC: begin
        if (accept_s && bus.in_last) state_next_s = IDLE;
        else                         state_next_s = ACC;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Configuration in force: live inputs on a group's first beat, latched copy afterwards.
  always_comb begin
    if (state_r == IDLE) begin
      chain_s = bus.active_chain;
      mask_s  = bus.prec;
    end else begin
      chain_s = cfg_chain_r;
      mask_s  = cfg_prec_r;
    end
  end

  // Lane adders one bit wider than the lane; differing top bits mean saturation.
  always_comb begin
    s0_s = 9'($signed({acc_r[7], acc_r[7:0]}) + $signed({bus.in_data[7], bus.in_data[7:0]}));
    s1_s = 9'($signed({acc_r[15], acc_r[15:8]}) + $signed({bus.in_data[15], bus.in_data[15:8]}));
    s2_s = 17'($signed({acc_r[31], acc_r[31:16]}) + $signed({bus.in_data[31], bus.in_data[31:16]}));
    s3_s = 33'($signed({acc_r[63], acc_r[63:32]}) + $signed({bus.in_data[63], bus.in_data[63:32]}));
    sc_s = 65'($signed({acc_r[63], acc_r}) + $signed({bus.in_data[63], bus.in_data}));
    sum_s     = 64'd0;
    sum_ovf_s = 4'd0;
    if (chain_s) begin
      if (sc_s[64] != sc_s[63]) begin
        sum_s        = sc_s[64] ? {1'b1, 63'd0} : {1'b0, {63{1'b1}}};
        sum_ovf_s[3] = 1'b1;
      end else begin
        sum_s = sc_s[63:0];
      end
    end else begin
      if (mask_s[0]) begin
        if (s0_s[8] != s0_s[7]) begin
          sum_s[7:0]   = s0_s[8] ? 8'h80 : 8'h7F;
          sum_ovf_s[0] = 1'b1;
        end else begin
          sum_s[7:0] = s0_s[7:0];
        end
      end else begin
        sum_s[7:0] = 8'h00;
      end
      if (mask_s[1]) begin
        if (s1_s[8] != s1_s[7]) begin
          sum_s[15:8]  = s1_s[8] ? 8'h80 : 8'h7F;
          sum_ovf_s[1] = 1'b1;
        end else begin
          sum_s[15:8] = s1_s[7:0];
        end
      end else begin
        sum_s[15:8] = 8'h00;
      end
      if (mask_s[2]) begin
        if (s2_s[16] != s2_s[15]) begin
          sum_s[31:16] = s2_s[16] ? 16'h8000 : 16'h7FFF;
          sum_ovf_s[2] = 1'b1;
        end else begin
          sum_s[31:16] = s2_s[15:0];
        end
      end else begin
        sum_s[31:16] = 16'h0000;
      end
      if (mask_s[3]) begin
        if (s3_s[32] != s3_s[31]) begin
          sum_s[63:32] = s3_s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
          sum_ovf_s[3] = 1'b1;
        end else begin
          sum_s[63:32] = s3_s[31:0];
        end
      end else begin
        sum_s[63:32] = 32'h0000_0000;
      end
    end
  end

  // Accumulator, beat count and sticky flags; all clear when a group closes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_r       <= 64'd0;
      cnt_r       <= {BEAT_W{1'b0}};
      ovf_r       <= 4'd0;
      cfg_prec_r  <= 4'd0;
      cfg_chain_r <= 1'b0;
    end else if (accept_s) begin
      if (bus.in_last) begin
        acc_r <= 64'd0;
        cnt_r <= {BEAT_W{1'b0}};
        ovf_r <= 4'd0;
      end else begin
        acc_r <= sum_s;
        cnt_r <= cnt_inc_s;
        ovf_r <= grp_ovf_s;
      end
      if (state_r == IDLE) begin
        cfg_prec_r  <= bus.prec;
        cfg_chain_r <= bus.active_chain;
      end
    end
  end

  // Two-entry result FIFO; the head register drives the outputs directly.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fill_r       <= 2'd0;
      head_data_r  <= 64'd0;
      head_beats_r <= {BEAT_W{1'b0}};
      head_ovf_r   <= 4'd0;
      tail_data_r  <= 64'd0;
      tail_beats_r <= {BEAT_W{1'b0}};
      tail_ovf_r   <= 4'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (fill_r == 2'd0) begin
            head_data_r  <= sum_s;
            head_beats_r <= cnt_inc_s;
            head_ovf_r   <= grp_ovf_s;
          end else begin
            tail_data_r  <= sum_s;
            tail_beats_r <= cnt_inc_s;
            tail_ovf_r   <= grp_ovf_s;
          end
          fill_r <= fill_r + 2'd1;
        end
        2'b01: begin
          if (fill_r == 2'd2) begin
            head_data_r  <= tail_data_r;
            head_beats_r <= tail_beats_r;
            head_ovf_r   <= tail_ovf_r;
          end
          fill_r <= fill_r - 2'd1;
        end
        2'b11: begin
          if (fill_r == 2'd2) begin
            head_data_r  <= tail_data_r;
            head_beats_r <= tail_beats_r;
            head_ovf_r   <= tail_ovf_r;
            tail_data_r  <= sum_s;
            tail_beats_r <= cnt_inc_s;
            tail_ovf_r   <= grp_ovf_s;
          end else begin
            head_data_r  <= sum_s;
            head_beats_r <= cnt_inc_s;
            head_ovf_r   <= grp_ovf_s;
          end
        end
        default: begin
          fill_r <= fill_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_lane_accumulator.sv
// Bench for dsp_lane_accumulator: directed groups with literal expectations plus
// a lane-arithmetic reference model compared against the outputs every cycle.
module tb_dsp_lane_accumulator;
  localparam int BEAT_W = 16;
  localparam int LO [4] = '{0, 8, 16, 32};
  localparam int WD [4] = '{8, 8, 16, 32};

  typedef logic signed [67:0] big_t;
  typedef struct packed {
    logic [63:0]       d;
    logic [BEAT_W-1:0] b;
    logic [3:0]        o;
  } res_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  dsp_lane_accumulator_if #(.BEAT_W(BEAT_W)) bus ();
  dsp_lane_accumulator #(.BEAT_W(BEAT_W), .OUT_DEPTH(2)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int   n_cmp = 0;
  int   n_fail = 0;
  res_t exp_q[$];
  big_t m_acc [4];
  int   m_cnt;
  logic [3:0] m_ovf, m_prec;
  logic m_chain;
  bit   m_grp;
  logic cmp_valid, cmp_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic big_t lane_get(input logic [63:0] d, input int lo, input int w);
    big_t u;
    u = $signed({4'b0000, d}) >>> lo;
    u = u & ((big_t'(1) <<< w) - big_t'(1));
    if (u[w-1]) u = u - (big_t'(1) <<< w);
    return u;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_acc[i] = '0;
    m_cnt = 0;
    m_ovf = 4'd0;
    m_grp = 1'b0;
  endtask

  // Reference: signed lane sums clipped to lane range, packed back into a word.
  task automatic model_beat(input logic [63:0] d, input logic last, input logic [3:0] p, input logic ch);
    big_t r, s, mx, mn;
    int wi, li, ob;
    if (!m_grp) begin
      m_prec  = p;
      m_chain = ch;
    end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_chain) begin
        wi = 64; li = 0; ob = 3;
      end else begin
        wi = WD[i]; li = LO[i]; ob = i;
      end
      if ((m_chain && i == 0) || (!m_chain && m_prec[i])) begin
        s  = m_acc[i] + lane_get(d, li, wi);
        mx = (big_t'(1) <<< (wi - 1)) - big_t'(1);
        mn = -(big_t'(1) <<< (wi - 1));
        if (s > mx) begin
          s = mx; m_ovf[ob] = 1'b1;
        end else if (s < mn) begin
          s = mn; m_ovf[ob] = 1'b1;
        end
        m_acc[i] = s;
        r = r | ((s & ((big_t'(1) <<< wi) - big_t'(1))) <<< li);
      end else begin
        m_acc[i] = '0;
      end
    end
    if (m_cnt < (2 ** BEAT_W) - 1) m_cnt++;
    if (last) begin
      exp_q.push_back('{d: r[63:0], b: m_cnt[BEAT_W-1:0], o: m_ovf});
      model_clear();
    end else begin
      m_grp = 1'b1;
    end
  endtask

  // Per-cycle comparison of handshake and result outputs against the model.
  initial begin
    model_clear();
    forever begin
      @(negedge CLK);
      if (RST) begin
        exp_q.delete();
        model_clear();
      end else begin
        cmp_valid = (exp_q.size() != 0);
        cmp_ready = (exp_q.size() < 2) || bus.out_ready;
        chk("out_valid", 64'(bus.out_valid), 64'(cmp_valid));
        chk("in_ready", 64'(bus.in_ready), 64'(cmp_ready));
        if (cmp_valid) begin
          chk("out_data", bus.out_data, exp_q[0].d);
          chk("out_beats", 64'(bus.out_beats), 64'(exp_q[0].b));
          chk("out_ovf", 64'(bus.out_ovf), 64'(exp_q[0].o));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
        if (bus.in_valid && cmp_ready)
          model_beat(bus.in_data, bus.in_last, bus.prec, bus.active_chain);
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic last, input logic [3:0] p, input logic ch);
    bit ok;
    ok = 1'b0;
    bus.in_data = d; bus.in_last = last; bus.prec = p; bus.active_chain = ch; bus.in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK); #1;
      if (k >= 3) bus.out_ready = 1'b1;
    end
    if (ok) begin
      @(posedge CLK); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: got in_ready 0 for 50 cycles, required 1");
    end
  endtask

  task automatic wait_out(input string name, input logic [63:0] d, input logic [BEAT_W-1:0] b, input logic [3:0] o);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      chk({name, "_data"}, bus.out_data, d);
      chk({name, "_beats"}, 64'(bus.out_beats), 64'(b));
      chk({name, "_ovf"}, 64'(bus.out_ovf), 64'(o));
    end else begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: got out_valid 0 for 20 cycles, required 1", name);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    bus.prec = 4'd0; bus.active_chain = 1'b0; bus.in_valid = 1'b0;
    bus.in_data = 64'd0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_out_beats", 64'(bus.out_beats), 64'd0);
    chk("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    @(posedge CLK); #1;

    // Single-beat group: result must be visible one cycle after acceptance.
    send(64'h00000003_0002_01_01, 1'b1, 4'hF, 1'b0);
    @(negedge CLK);
    chk("single_valid", 64'(bus.out_valid), 64'd1);
    chk("single_data", bus.out_data, 64'h00000003_0002_01_01);
    chk("single_beats", 64'(bus.out_beats), 64'd1);
    chk("single_ovf", 64'(bus.out_ovf), 64'd0);
    @(posedge CLK); #1;

    send(64'h7FFFFFFF_0000_80_7F, 1'b0, 4'hF, 1'b0);
    send(64'h00000001_0000_FF_01, 1'b1, 4'hF, 1'b0);
    wait_out("sat", 64'h7FFFFFFF_0000_80_7F, 16'd2, 4'b1011);

    send(64'h7FFFFFFF_FFFFFFF0, 1'b0, 4'h0, 1'b1);
    send(64'h00000000_00000020, 1'b1, 4'h0, 1'b1);
    wait_out("chain_pos", 64'h7FFFFFFF_FFFFFFFF, 16'd2, 4'b1000);
    send(64'h80000000_00000000, 1'b0, 4'h0, 1'b1);
    send(64'hFFFFFFFF_FFFFFFFF, 1'b1, 4'h0, 1'b0);
    wait_out("chain_neg", 64'h80000000_00000000, 16'd2, 4'b1000);

    send(64'hFFFFFFFF_FFFF_FF_01, 1'b0, 4'b0101, 1'b0);
    send(64'hFFFFFFFF_FFFF_FF_01, 1'b0, 4'hF, 1'b0);
    send(64'hFFFFFFFF_FFFF_FF_01, 1'b1, 4'b0101, 1'b0);
    wait_out("disabled", 64'h00000000_FFFD_00_03, 16'd3, 4'b0000);

    // Backpressure: two results fill the buffer, the third beat waits for a pop.
    bus.out_ready = 1'b0;
    send(64'd1, 1'b1, 4'hF, 1'b0);
    send(64'd2, 1'b1, 4'hF, 1'b0);
    bus.in_data = 64'd3; bus.in_last = 1'b1; bus.prec = 4'hF; bus.in_valid = 1'b1;
    @(negedge CLK);
    chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_head", bus.out_data, 64'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("bp_stall_ready", 64'(bus.in_ready), 64'd0);
    @(posedge CLK); #1;
    bus.out_ready = 1'b1;
    @(negedge CLK);
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_first", bus.out_data, 64'd1);
    @(posedge CLK); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    @(negedge CLK);
    chk("bp_second", bus.out_data, 64'd2);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("bp_third", bus.out_data, 64'd3);
    chk("bp_third_valid", 64'(bus.out_valid), 64'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("bp_empty", 64'(bus.out_valid), 64'd0);
    @(posedge CLK); #1;

    // Reset in the middle of an open group discards the partial sum.
    send(64'd5, 1'b0, 4'hF, 1'b0);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    send(64'd2, 1'b1, 4'hF, 1'b0);
    wait_out("rst_mid", 64'd2, 16'd1, 4'b0000);

    for (int i = 0; i < 40; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      send({$urandom, $urandom}, (i == 39) || ($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)), $urandom_range(0, 4) == 0);
    end
    bus.out_ready = 1'b1;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    chk("drained", 64'(bus.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, required $finish before 500000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dsp_lane_accumulator.md
Name: dsp_lane_accumulator

Overview:
- Sits directly downstream of the 64-bit multi-precision MAC.
- Consumes its 64-bit P word, which carries lanes 8/8/16/32 or one chained 64-bit lane. Adds each lane signed and saturating over a group of beats, then delivers the group result through a 2-entry valid/ready output buffer to the drain logic.
- Lane enables and chain mode use the same encoding as the MAC: the CE mask and active_chain.

Parameters:
- BEAT_W, 16, width of the per-group beat counter. The counter saturates at 2^BEAT_W-1.
- OUT_DEPTH, 2, number of output buffer entries. Only 2 is supported.

Ports:
- CLK  in  1  clock, all logic on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- prec  in  4  lane enable mask, MAC CE encoding: bit0 = lane [7:0], bit1 = [15:8], bit2 = [31:16], bit3 = [63:32].
- active_chain  in  1  1 = treat in_data as a single signed 64-bit lane.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  64  MAC P word.
- in_last  in  1  marks the final beat of a group.
- out_valid  out  1  group result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  64  saturated lane sums, packed like in_data.
- out_beats  out  BEAT_W  number of beats in the group.
- out_ovf  out  4  per-lane sticky saturation flags. Chained mode reports on bit3 only.

Behaviour:
- Reset:
  - acc = 0, beat count = 0, ovf = 0, buffer empty, state IDLE, configuration registers = 0.
  - out_valid = 0; out_data, out_beats and out_ovf = 0.
  - in_ready = 1 once RST is deasserted.
  - RST mid-group discards the partial sum and any buffered results.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- in_ready rule: in_ready = (buffer count < 2) || out_ready. One entry freed and one pushed in the same cycle is legal.
- State machine:
  - IDLE -> ACC on an accepted beat with in_last = 0. prec and active_chain are latched on that first beat.
  - ACC -> ACC on accepted non-last beats. prec and active_chain are ignored; the latched values are used.
  - ACC -> IDLE on an accepted last beat.
  - IDLE -> IDLE on an accepted beat with in_last = 1. This is a single-beat group; configuration is taken from the live inputs.
- Arithmetic:
  - Each enabled lane computes sum = acc_lane + in_lane in lane-width + 1 bits, both operands signed.
  - Result > max gives max; result < min gives min. Either case sets the lane's ovf bit.
  - Disabled lanes (latched prec bit = 0) are forced to 0, never set ovf, and in_data for those lanes is ignored.
  - Chained mode: one 64-bit signed lane with 64-bit saturation. prec is ignored and all bits of the latched mask are treated as 1.
- Group completion:
  - On an accepted last beat, the final sum, beats = count + 1 (saturating) and ovf (including that beat's overflow) are pushed into the buffer in the same cycle.
  - acc, count and ovf clear to 0 in that same cycle.
  - out_valid rises the next cycle.
- Latency: last beat accepted at cycle t gives out_valid = 1 at t+1 when the buffer was empty.
- Output buffer: FIFO order. out_data, out_beats and out_ovf are registered and hold stable while out_valid && !out_ready.
- Full buffer: with count == 2 and out_ready = 0, in_ready = 0. This stalls non-last beats as well, so the accumulator is frozen.
- Empty buffer: out_valid = 0 and outputs hold their last values. No underflow is possible.
- Simultaneous pop and push with count == 2: both happen, and count stays 2.
- Beat counter: at saturation (2^BEAT_W-1) it stays at that value and accumulation continues.

Test Plan:
- Reset with out_ready = 1 -> in_ready = 1, out_valid = 0, out_data = 0.
- Non-chained, prec = 4'hF, one beat with in_data = 0x00000003_0002_01_01 and in_last = 1 -> next cycle out_data = 0x00000003_0002_01_01, out_beats = 1, out_ovf = 0.
- Lane saturation, prec = 4'hF:
  - Beats: lane0 = 0x7F, then lane0 = 0x01; lane1 = 0x80, then lane1 = 0xFF; lane3 = 0x7FFFFFFF, then 0x00000001; last on beat 2.
  - Expected: lane0 = 0x7F, lane1 = 0x80, lane3 = 0x7FFFFFFF, out_ovf = 4'b1011, out_beats = 2.
- Chained mode: beats 0x7FFFFFFF_FFFFFFF0 then 0x20 with last -> out_data = 0x7FFFFFFF_FFFFFFFF, out_ovf = 4'b1000. Then beats 0x80000000_00000000 and 0xFFFFFFFF_FFFFFFFF -> out_data = 0x80000000_00000000.
- Disabled lanes: prec = 4'b0101, in_data = 0xFFFFFFFF_FFFF_FF_01 for 3 beats -> out_data = 0x00000000_FFFD_00_03.
  - Lane2 is enabled and sums 0xFFFF three times to 0xFFFD, which is -3, so no saturation. Lanes 1 and 3 are disabled and read 0.
  - A prec change to 4'hF on beat 2 has no effect.
- Backpressure:
  - With out_ready = 0, send three single-beat groups with values 1, 2, 3. in_ready drops after the second push and the third stalls.
  - Raise out_ready -> results appear in order 1, 2, 3 with no loss. The third beat is accepted in the same cycle the first is popped.
- Reset mid-group: accumulate 5 on lane0, assert RST for 1 cycle, then send one beat of 2 with in_last -> out_data lane0 = 2, out_beats = 1.
